// File: rtl/key_led_mode_ctrl.sv
// Push-key / LED board controller: synchronizes and debounces four active-low keys,
// round-robin arbitrates their press events into commands, and sequences four LED display modes.
module key_led_mode_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int CW          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       running,
  output logic [3:0] grant
);

  typedef enum logic [1:0] {
    COUNT_UP = 2'd0,
    COUNT_DN = 2'd1,
    SHIFT    = 2'd2,
    BLINK    = 2'd3
  } mode_e;

  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_CYCLES - 1);

  function automatic logic [3:0] init_led(input mode_e m);
    case (m)
      COUNT_DN: init_led = 4'b1111;
      SHIFT:    init_led = 4'b0001;
      default:  init_led = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] adv_led(input mode_e m, input logic [3:0] l);
    case (m)
      COUNT_UP: adv_led = l + 4'd1;
      COUNT_DN: adv_led = l - 4'd1;
      SHIFT:    adv_led = {l[2:0], l[3]};
      default:  adv_led = ~l;
    endcase
  endfunction

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    deb_q, deb_d;
  logic [CW-1:0] deb_cnt_q [4];
  logic [CW-1:0] deb_cnt_d [4];
  logic [3:0]    press;
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    idx;
  logic          found;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick, cnt_clr;
  logic [3:0]    led_q, led_d;
  mode_e         mode_q, mode_d, next_mode;
  logic          running_q, running_d;

  // Input path: two-flop synchronizer, then a per-key stability counter.
  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
    for (int i = 0; i < 4; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) deb_d[i] = sync2_q[i];
        else                         deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
      end
    end
    press = deb_q & ~deb_d;
  end

  // Round-robin search from ptr; a press landing on the granted key keeps it pending.
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && pending_q[idx]) begin
        grant_d[idx] = 1'b1;
        ptr_d        = idx + 2'd1;
        found        = 1'b1;
      end
    end
    pending_d = (pending_q & ~grant_d) | press;
  end

  // Display: the registered grant is the command; it pre-empts a coincident tick.
  always_comb begin
    tick      = running_q && (tick_cnt_q == TICK_MAX);
    next_mode = mode_e'(mode_q + 2'd1);
    led_d     = led_q;
    mode_d    = mode_q;
    running_d = running_q;
    cnt_clr   = 1'b0;
    if (grant_q[0]) begin
      mode_d  = next_mode;
      led_d   = init_led(next_mode);
      cnt_clr = 1'b1;
    end else if (grant_q[1]) begin
      running_d = ~running_q;
      cnt_clr   = 1'b1;
    end else if (grant_q[2]) begin
      if (!running_q) led_d = adv_led(mode_q, led_q);
    end else if (grant_q[3]) begin
      led_d   = init_led(mode_q);
      cnt_clr = 1'b1;
    end else if (tick) begin
      led_d = adv_led(mode_q, led_q);
    end
    if (!running_q || cnt_clr || tick) tick_cnt_d = '0;
    else                               tick_cnt_d = tick_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      deb_q      <= 4'b1111;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      pending_q  <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      tick_cnt_q <= '0;
      led_q      <= 4'b0000;
      mode_q     <= COUNT_UP;
      running_q  <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tick_cnt_q <= tick_cnt_d;
      led_q      <= led_d;
      mode_q     <= mode_d;
      running_q  <= running_d;
    end
  end

  assign led     = led_q;
  assign mode    = mode_q;
  assign running = running_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// Directed bench for key_led_mode_ctrl with DEB_CYCLES=4, TICK_CYCLES=8:
// a command table for the paused display plus hand-timed sequences for arbitration, priority and reset.
module tb_key_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'b1111;
  logic [3:0] led;
  logic [1:0] mode;
  logic       running;
  logic [3:0] grant;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] mask;
    int         reps;
    logic [3:0] led;
    logic [1:0] mode;
    logic       run;
  } vec_t;

  vec_t tbl[15];

  key_led_mode_ctrl #(.DEB_CYCLES(4), .TICK_CYCLES(8), .CW(24)) dut (
    .clk(clk), .rst(rst), .key(key), .led(led), .mode(mode), .running(running), .grant(grant)
  );

  // clock / reset
  always #5 clk = ~clk;

  // grant scoreboard: every nonzero grant must match the next expected one
  always @(negedge clk) begin
    logic [3:0] e;
    if (grant !== 4'b0000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_grant: got %b, expected none", grant);
      end else begin
        e = exp_q.pop_front();
        if (grant !== e) begin
          n_err++;
          $display("FAIL grant_order: got %b, expected %b", grant, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_led"}, led, 4'b0000);
    check({tag, "_mode"}, {2'b00, mode}, 4'd0);
    check({tag, "_running"}, {3'b000, running}, 4'd1);
    check({tag, "_grant"}, grant, 4'b0000);
  endtask

  // driver: one clean press of the keys in mask, then release and settle
  task automatic press(input logic [3:0] mask);
    if (mask != 4'b0000) exp_q.push_back(mask);
    key = key & ~mask;
    cyc(8);
    key = key | mask;
    cyc(14);
  endtask

  initial begin
    tbl[0]  = '{4'b1000,  1, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100,  2, 4'b0010, 2'd0, 1'b0};
    tbl[2]  = '{4'b0001,  1, 4'b1111, 2'd1, 1'b0};
    tbl[3]  = '{4'b0100, 15, 4'b0000, 2'd1, 1'b0};
    tbl[4]  = '{4'b0100,  1, 4'b1111, 2'd1, 1'b0};
    tbl[5]  = '{4'b0001,  1, 4'b0001, 2'd2, 1'b0};
    tbl[6]  = '{4'b0100,  3, 4'b1000, 2'd2, 1'b0};
    tbl[7]  = '{4'b0100,  1, 4'b0001, 2'd2, 1'b0};
    tbl[8]  = '{4'b0001,  1, 4'b0000, 2'd3, 1'b0};
    tbl[9]  = '{4'b0100,  1, 4'b1111, 2'd3, 1'b0};
    tbl[10] = '{4'b0100,  1, 4'b0000, 2'd3, 1'b0};
    tbl[11] = '{4'b0001,  1, 4'b0000, 2'd0, 1'b0};
    tbl[12] = '{4'b0100,  1, 4'b0001, 2'd0, 1'b0};
    tbl[13] = '{4'b1000,  1, 4'b0000, 2'd0, 1'b0};
    tbl[14] = '{4'b0000,  2, 4'b0000, 2'd0, 1'b0};

    // reset and free-running count-up
    #3 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    cyc(2);
    rst = 1'b1;
    cyc(7);  check("cnt_before_tick", led, 4'b0000);
    cyc(1);  check("cnt_tick1", led, 4'b0001);
    cyc(8);  check("cnt_tick2", led, 4'b0010);
    cyc(8);  check("cnt_tick3", led, 4'b0011);

    // bounce shorter than the debounce window: no grant
    key[1] = 1'b0;
    cyc(2);
    key[1] = 1'b1;
    cyc(12);

    // key1 held 10 cycles: one grant with fixed latency, display pauses
    exp_q.push_back(4'b0010);
    key[1] = 1'b0;
    cyc(6);  check("run_grant_early", grant, 4'b0000);
    cyc(1);  check("run_grant", grant, 4'b0010);
    cyc(1);  check("run_paused", {3'b000, running}, 4'd0);
    cyc(2);
    key[1] = 1'b1;
    cyc(14);
    check("run_no_regrant", {3'b000, running}, 4'd0);

    // paused command table
    for (int v = 0; v < 15; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) press(tbl[v].mask);
      check($sformatf("tbl%0d_led", v), led, tbl[v].led);
      check($sformatf("tbl%0d_mode", v), {2'b00, mode}, {2'b00, tbl[v].mode});
      check($sformatf("tbl%0d_running", v), {3'b000, running}, {3'b000, tbl[v].run});
    end

    // all four keys in the same cycle, ptr at 0
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    key = 4'b0000;
    cyc(7);  check("rr_g0", grant, 4'b0001);
    cyc(1);  check("rr_g1", grant, 4'b0010);
    cyc(1);  check("rr_g2", grant, 4'b0100);
    cyc(1);  check("rr_g3", grant, 4'b1000);
    cyc(1);
    check("rr_idle", grant, 4'b0000);
    check("rr_led", led, 4'b1111);
    check("rr_mode", {2'b00, mode}, 4'd1);
    check("rr_running", {3'b000, running}, 4'd1);
    cyc(7);  check("rr_pre_tick", led, 4'b1111);
    cyc(1);  check("rr_tick_dn", led, 4'b1110);
    key = 4'b1111;
    cyc(14);

    // key3 grant coinciding with a tick: clear wins, next tick 8 cycles later
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    key[0] = 1'b0;
    cyc(8);
    check("tk_mode", {2'b00, mode}, 4'd2);
    check("tk_led_init", led, 4'b0001);
    key[3] = 1'b0;
    cyc(7);
    check("tk_grant", grant, 4'b1000);
    check("tk_led_pre", led, 4'b0001);
    cyc(1);  check("tk_clear_wins", led, 4'b0001);
    cyc(7);  check("tk_next_pre", led, 4'b0001);
    cyc(1);  check("tk_next_tick", led, 4'b0010);
    check("tk_mode_kept", {2'b00, mode}, 4'd2);
    key = 4'b1111;
    cyc(14);

    // reset in the middle of a key2 debounce
    key[2] = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    check_reset_vals("midrst");
    key = 4'b1111;
    cyc(2);
    rst = 1'b1;
    cyc(8);  check("midrst_tick", led, 4'b0001);
    cyc(20);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL grants_outstanding: got %0d missing, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
